// File: rtl/pwm_cmd_sequencer.sv
// Two-source motor command front-end for the PWM block: priority arbitration,
// per-byte slew limiting toward the accepted target, and a watchdog failsafe to neutral.
module pwm_cmd_sequencer #(
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned STEP          = 8,
    parameter int unsigned TIMEOUT_TICKS = 500,
    parameter int unsigned HOLD_TICKS    = 250,
    parameter logic [7:0]  NEUTRAL_DIR   = 8'h80,
    parameter logic [7:0]  NEUTRAL_SPD   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [15:0] m_data,
    output logic        m_ready,
    output logic [15:0] cmd_out,
    output logic        busy,
    output logic        timeout,
    output logic        src
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [15:0] NEUTRAL = {NEUTRAL_DIR, NEUTRAL_SPD};

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAMP     = 2'd1;
    localparam logic [1:0] ST_FAILSAFE = 2'd2;

    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   target_q, target_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          src_q, src_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    state_q, state_d;

    logic tick, accept_m, accept_a, accept, expire;

    // One slew step of a single byte; never wraps and never overshoots.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        if (diff <= 8'(STEP)) begin
            return tgt;
        end
        return (tgt > cur) ? (cur + 8'(STEP)) : (cur - 8'(STEP));
    endfunction

    assign m_ready = enable & ~rst;
    assign a_ready = enable & ~rst & ~m_valid & (hold_q == '0);

    assign cmd_out = cmd_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign src     = src_q;

    always_comb begin
        cmd_d     = cmd_q;
        target_d  = target_q;
        timeout_d = timeout_q;
        src_d     = src_q;
        presc_d   = presc_q;
        wdog_d    = wdog_q;
        hold_d    = hold_q;
        state_d   = state_q;
        tick      = (presc_q == PW'(TICK_DIV - 1));
        accept_m  = m_valid & m_ready;
        accept_a  = a_valid & a_ready;
        accept    = accept_m | accept_a;
        expire    = 1'b0;

        if (!enable) begin
            cmd_d     = NEUTRAL;
            target_d  = NEUTRAL;
            timeout_d = 1'b0;
            presc_d   = '0;
            wdog_d    = '0;
            hold_d    = '0;
            state_d   = ST_IDLE;
        end else begin
            presc_d = tick ? '0 : (presc_q + PW'(1));
            // Ramp uses the pre-accept target so a new command moves on the following tick.
            if (tick) begin
                cmd_d = {slew(cmd_q[15:8], target_q[15:8]), slew(cmd_q[7:0], target_q[7:0])};
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end
            end
            if (accept_m) begin
                hold_d = HW'(HOLD_TICKS);
            end
            if (accept) begin
                target_d  = accept_m ? m_data : a_data;
                src_d     = accept_m;
                wdog_d    = '0;
                timeout_d = 1'b0;
            end else if (tick && (wdog_q != WW'(TIMEOUT_TICKS))) begin
                wdog_d = wdog_q + WW'(1);
                if (wdog_q == WW'(TIMEOUT_TICKS - 1)) begin
                    expire    = 1'b1;
                    target_d  = NEUTRAL;
                    timeout_d = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE, ST_RAMP: begin
                    if (expire) state_d = ST_FAILSAFE;
                    else        state_d = (cmd_d != target_d) ? ST_RAMP : ST_IDLE;
                end
                ST_FAILSAFE: begin
                    if (accept) state_d = (cmd_d != target_d) ? ST_RAMP : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (cmd_d != target_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= NEUTRAL;
            target_q  <= NEUTRAL;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            src_q     <= 1'b0;
            presc_q   <= '0;
            wdog_q    <= '0;
            hold_q    <= '0;
            state_q   <= ST_IDLE;
        end else begin
            cmd_q     <= cmd_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            src_q     <= src_d;
            presc_q   <= presc_d;
            wdog_q    <= wdog_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

endmodule
